// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the fetch/execute datapath.
// Walks steps T0..T7. Memory steps stretch until MemReady is seen.
// All datapath strobes, the ALU opcode and memory Read/Write are decoded from the step register.
module control_sequencer #(
    parameter logic [4:0] OP_LD   = 5'b00000,
    parameter logic [4:0] OP_LDI  = 5'b00001,
    parameter logic [4:0] OP_ST   = 5'b00010,
    parameter logic [4:0] OP_ADD  = 5'b00011,
    parameter logic [4:0] OP_SUB  = 5'b00100,
    parameter logic [4:0] OP_AND  = 5'b00101,
    parameter logic [4:0] OP_OR   = 5'b00110,
    parameter logic [4:0] OP_ADDI = 5'b01100,
    parameter logic [4:0] OP_NOP  = 5'b11010,
    parameter logic [4:0] OP_HALT = 5'b11011
) (
    input  logic        Clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        MemReady,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  opcode,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Cout,
    output logic        Run,
    output logic        IllegalOp
);

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    state_t     state;
    logic [4:0] op_q;
    logic [4:0] ir_op;
    logic       unused_ir;

    assign ir_op     = IR[31:27];
    assign unused_ir = ^IR[26:0];

    // Instructions that form an address or immediate as base + constant.
    function automatic logic is_base_plus_c(input logic [4:0] op);
        return (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
    endfunction

    // Register-register ALU instructions; their own opcode drives the ALU.
    function automatic logic is_alu_rr(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    // Instructions that continue past T3.
    function automatic logic needs_t4(input logic [4:0] op);
        return is_base_plus_c(op) || is_alu_rr(op) || (op == OP_ADDI);
    endfunction

    // Step sequencing; the opcode is captured when leaving T3 so later steps ignore IR.
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state <= S_RST;
            op_q  <= '0;
        end else begin
            case (state)
                S_RST:  state <= S_T0;
                S_T0:   state <= S_T1;
                S_T1:   if (MemReady) state <= S_T2;
                S_T2:   state <= S_T3;
                S_T3: begin
                    op_q <= ir_op;
                    if (ir_op == OP_HALT)
                        state <= S_HALT;
                    else if (needs_t4(ir_op))
                        state <= S_T4;
                    else
                        state <= S_T0;
                end
                S_T4:   state <= S_T5;
                S_T5:   state <= ((op_q == OP_LD) || (op_q == OP_ST)) ? S_T6 : S_T0;
                S_T6:   if ((op_q == OP_ST) || MemReady) state <= S_T7;
                S_T7:   if ((op_q == OP_LD) || MemReady) state <= S_T0;
                S_HALT: state <= S_HALT;
                default: state <= S_RST;
            endcase
        end
    end

    // Strobe decode from the step register; T3 looks at the freshly loaded IR.
    always_comb begin
        Read      = 1'b0;
        Write     = 1'b0;
        opcode    = 5'b0;
        Gra       = 1'b0;
        Grb       = 1'b0;
        Grc       = 1'b0;
        Rin       = 1'b0;
        Rout      = 1'b0;
        BAout     = 1'b0;
        PCout     = 1'b0;
        PCin      = 1'b0;
        IncPC     = 1'b0;
        MARin     = 1'b0;
        MDRin     = 1'b0;
        MDRout    = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        Zin       = 1'b0;
        Zlowout   = 1'b0;
        Cout      = 1'b0;
        IllegalOp = 1'b0;
        Run       = (state != S_HALT);
        case (state)
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            S_T3: begin
                if (is_base_plus_c(ir_op)) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                end else if (is_alu_rr(ir_op) || (ir_op == OP_ADDI)) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if ((ir_op != OP_NOP) && (ir_op != OP_HALT)) begin
                    IllegalOp = 1'b1;
                end
            end
            S_T4: begin
                Zin = 1'b1;
                if (is_alu_rr(op_q)) begin
                    Grc = 1'b1; Rout = 1'b1; opcode = op_q;
                end else begin
                    Cout = 1'b1; opcode = OP_ADD;
                end
            end
            S_T5: begin
                Zlowout = 1'b1;
                if ((op_q == OP_LD) || (op_q == OP_ST)) begin
                    MARin = 1'b1;
                end else begin
                    Gra = 1'b1; Rin = 1'b1;
                end
            end
            S_T6: begin
                MDRin = 1'b1;
                if (op_q == OP_ST) begin
                    Gra = 1'b1; Rout = 1'b1;
                end else begin
                    Read = 1'b1;
                end
            end
            S_T7: begin
                MDRout = 1'b1;
                if (op_q == OP_ST) begin
                    Write = 1'b1;
                end else begin
                    Gra = 1'b1; Rin = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: a per-instruction step table built from
// the instruction set rules predicts every cycle's strobes, including memory waits.
module tb_control_sequencer;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [20:0] M_READ    = 21'b1 << 0;
    localparam logic [20:0] M_WRITE   = 21'b1 << 1;
    localparam logic [20:0] M_GRA     = 21'b1 << 2;
    localparam logic [20:0] M_GRB     = 21'b1 << 3;
    localparam logic [20:0] M_GRC     = 21'b1 << 4;
    localparam logic [20:0] M_RIN     = 21'b1 << 5;
    localparam logic [20:0] M_ROUT    = 21'b1 << 6;
    localparam logic [20:0] M_BAOUT   = 21'b1 << 7;
    localparam logic [20:0] M_PCOUT   = 21'b1 << 8;
    localparam logic [20:0] M_PCIN    = 21'b1 << 9;
    localparam logic [20:0] M_INCPC   = 21'b1 << 10;
    localparam logic [20:0] M_MARIN   = 21'b1 << 11;
    localparam logic [20:0] M_MDRIN   = 21'b1 << 12;
    localparam logic [20:0] M_MDROUT  = 21'b1 << 13;
    localparam logic [20:0] M_IRIN    = 21'b1 << 14;
    localparam logic [20:0] M_YIN     = 21'b1 << 15;
    localparam logic [20:0] M_ZIN     = 21'b1 << 16;
    localparam logic [20:0] M_ZLOWOUT = 21'b1 << 17;
    localparam logic [20:0] M_COUT    = 21'b1 << 18;
    localparam logic [20:0] M_RUN     = 21'b1 << 19;
    localparam logic [20:0] M_ILL     = 21'b1 << 20;

    typedef struct packed {
        logic [20:0] s;
        logic [4:0]  op;
        logic        w;
    } step_t;

    logic        Clock;
    logic        clear;
    logic [31:0] IR;
    logic        MemReady;
    logic        Read, Write;
    logic [4:0]  opcode;
    logic        Gra, Grb, Grc, Rin, Rout, BAout;
    logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout;
    logic        Run, IllegalOp;
    logic [20:0] dut_vec;

    step_t       plan[$];
    int          total;
    int          bad;
    logic [4:0]  legal_ops[9];

    control_sequencer dut (
        .Clock(Clock), .clear(clear), .IR(IR), .MemReady(MemReady),
        .Read(Read), .Write(Write), .opcode(opcode),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
        .Cout(Cout), .Run(Run), .IllegalOp(IllegalOp)
    );

    assign dut_vec = {IllegalOp, Run, Cout, Zlowout, Zin, Yin, IRin, MDRout, MDRin, MARin,
                      IncPC, PCin, PCout, BAout, Rout, Rin, Grc, Grb, Gra, Write, Read};

    // Free-running clock, 10 time units per period.
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Hard stop in case the sequencer never returns where expected.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic mem_ready);
        MemReady = mem_ready;
    endtask

    function automatic void addStep(input logic [20:0] s, input logic [4:0] op, input logic w);
        step_t st;
        st.s  = s | M_RUN;
        st.op = op;
        st.w  = w;
        plan.push_back(st);
    endfunction

    // Expected cycle-by-cycle behaviour of one instruction, starting at T0.
    function automatic void buildPlan(input logic [4:0] opc);
        plan.delete();
        addStep(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'b0, 1'b0);
        addStep(M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 5'b0, 1'b1);
        addStep(M_MDROUT | M_IRIN, 5'b0, 1'b0);
        if (opc == OP_LD || opc == OP_LDI || opc == OP_ST) begin
            addStep(M_GRB | M_BAOUT | M_YIN, 5'b0, 1'b0);
            addStep(M_COUT | M_ZIN, OP_ADD, 1'b0);
            if (opc == OP_LDI) begin
                addStep(M_ZLOWOUT | M_GRA | M_RIN, 5'b0, 1'b0);
            end else begin
                addStep(M_ZLOWOUT | M_MARIN, 5'b0, 1'b0);
                if (opc == OP_LD) begin
                    addStep(M_READ | M_MDRIN, 5'b0, 1'b1);
                    addStep(M_MDROUT | M_GRA | M_RIN, 5'b0, 1'b0);
                end else begin
                    addStep(M_GRA | M_ROUT | M_MDRIN, 5'b0, 1'b0);
                    addStep(M_MDROUT | M_WRITE, 5'b0, 1'b1);
                end
            end
        end else if (opc inside {OP_ADD, OP_SUB, OP_AND, OP_OR}) begin
            addStep(M_GRB | M_ROUT | M_YIN, 5'b0, 1'b0);
            addStep(M_GRC | M_ROUT | M_ZIN, opc, 1'b0);
            addStep(M_ZLOWOUT | M_GRA | M_RIN, 5'b0, 1'b0);
        end else if (opc == OP_ADDI) begin
            addStep(M_GRB | M_ROUT | M_YIN, 5'b0, 1'b0);
            addStep(M_COUT | M_ZIN, OP_ADD, 1'b0);
            addStep(M_ZLOWOUT | M_GRA | M_RIN, 5'b0, 1'b0);
        end else if (opc == OP_NOP || opc == OP_HALT) begin
            addStep(21'b0, 5'b0, 1'b0);
        end else begin
            addStep(M_ILL, 5'b0, 1'b0);
        end
    endfunction

    // Runs one instruction from T0; hold_n<0 gives random capped waits, else exactly hold_n.
    task automatic runInstr(input logic [4:0] opc, input int hold_n);
        int idx;
        int waits;
        buildPlan(opc);
        IR = {opc, 27'($urandom)};
        idx = 0;
        waits = 0;
        while (idx < plan.size()) begin
            if (hold_n < 0)
                applyStimulus((waits < 4) ? ($urandom_range(0, 1) == 1) : 1'b1);
            else
                applyStimulus(waits >= hold_n);
            @(negedge Clock);
            checkOutput($sformatf("op%b_step%0d_strobes", opc, idx),
                        32'(dut_vec), 32'(plan[idx].s));
            checkOutput($sformatf("op%b_step%0d_opcode", opc, idx),
                        32'(opcode), 32'(plan[idx].op));
            @(posedge Clock);
            #1;
            if (plan[idx].w && !MemReady) begin
                waits++;
            end else begin
                idx++;
                waits = 0;
            end
        end
    endtask

    // Releases reset at a falling edge and lands just after the RST->T0 edge.
    task automatic releaseReset();
        @(negedge Clock);
        clear = 1'b1;
        @(posedge Clock);
        #1;
    endtask

    // Main sequence: reset, directed cases, then a random instruction stream.
    initial begin
        logic [4:0] pick;
        total = 0;
        bad = 0;
        legal_ops = '{OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_NOP};
        clear = 1'b0;
        IR = 32'h0;
        MemReady = 1'b0;
        #2;
        checkOutput("reset_strobes", 32'(dut_vec), 32'(M_RUN));
        checkOutput("reset_opcode", 32'(opcode), 32'h0);
        releaseReset();

        runInstr(OP_LD, 0);
        IR = 32'h0200_0058;
        runInstr(OP_SUB, 0);
        runInstr(OP_ST, 3);
        runInstr(OP_NOP, 5);
        runInstr(5'b11111, 0);
        runInstr(OP_LDI, 2);
        runInstr(OP_ADDI, 0);

        applyStimulus(1'b0);
        @(negedge Clock);
        checkOutput("pre_t1_strobes", 32'(dut_vec), 32'(M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZIN));
        @(posedge Clock);
        #1;
        @(negedge Clock);
        checkOutput("t1_read", 32'(dut_vec), 32'(M_RUN | M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN));
        #2;
        clear = 1'b0;
        #1;
        checkOutput("async_reset_drop", 32'(dut_vec), 32'(M_RUN));
        @(posedge Clock);
        #1;
        checkOutput("reset_hold", 32'(dut_vec), 32'(M_RUN));
        releaseReset();

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 11) < 9) begin
                pick = legal_ops[$urandom_range(0, 8)];
            end else begin
                pick = 5'($urandom);
                if (pick == OP_HALT) pick = 5'b11111;
            end
            runInstr(pick, -1);
        end

        runInstr(OP_HALT, 0);
        for (int n = 0; n < 22; n++) begin
            applyStimulus($urandom_range(0, 1) == 1);
            IR = $urandom;
            @(negedge Clock);
            checkOutput($sformatf("halt_cycle%0d_strobes", n), 32'(dut_vec), 32'h0);
            checkOutput($sformatf("halt_cycle%0d_opcode", n), 32'(opcode), 32'h0);
        end
        clear = 1'b0;
        #1;
        checkOutput("halt_reset", 32'(dut_vec), 32'(M_RUN));
        releaseReset();
        runInstr(OP_AND, 1);
        applyStimulus(1'b1);
        @(negedge Clock);
        checkOutput("final_t0", 32'(dut_vec), 32'(M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZIN));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
